jtag_host: RTL and testbench
============================

# jtag_host

Host-side JTAG scan engine: the initiator that drives the TAP pins of the team's JTAG test logic from a parallel command interface. It generates TCK from the system clock, sequences TMS through the TAP state diagram, shifts TDI out LSB-first and captures TDO into a response word. It sits inside an on-chip debug/test bridge or in the board-level bench harness that exercises the boundary-scan target.

## Interface
- CLK_DIV, 2: system clocks per TCK half-period (≥1)
- MAX_LEN, 32: maximum scan length in bits; LW = $clog2(MAX_LEN+1)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&ready
- cmd_op  in  2  0=DR scan, 1=IR scan, 2=TAP reset, 3=reserved (treated as TAP reset)
- cmd_len  in  LW  scan length in bits
- cmd_data  in  MAX_LEN  TDI bits, bit 0 shifted first
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when valid&ready
- rsp_data  out  MAX_LEN  captured TDO, bit i = i-th shifted bit, unused MSBs 0
- busy  out  1  high whenever not in IDLE
- tck  out  1  JTAG clock to target
- tms  out  1  JTAG mode select
- tdi  out  1  JTAG data to target
- tdo  in  1  JTAG data from target

## Operation
- Internal TAP-state tracking; the host parks the target in Run-Test/Idle between commands.
- States: RST_SEQ → IDLE → (PRE → SHIFT → POST | RST_SEQ) → RESP → IDLE.
- RST_SEQ: TMS=1 for 5 TCK periods, then TMS=0 for 1 (Test-Logic-Reset → Run-Test/Idle). Entered automatically after reset and for cmd_op 2/3.
- DR PRE: TMS 1,0 (Select-DR, Capture-DR). IR PRE: TMS 1,1,0 (Select-DR, Select-IR, Capture-IR). Then one TMS=0 period enters Shift.
- SHIFT: cmd_len periods; TDI = current data bit; TMS=0 except the last bit, where TMS=1 (Exit1).
- POST: TMS 1 (Update), 0 (Run-Test/Idle).
- TCK periods: DR = len+5, IR = len+6, reset = 6.
- Data shift register loaded from cmd_data on accept; TDO shifted in at MSB side of an len-aligned capture, so rsp_data bit i = TDO at i-th shift edge.
- cmd_len 0: no TCK activity; straight to RESP with rsp_data = 0. cmd_len > MAX_LEN: clamped to MAX_LEN.
- TAP reset commands produce a response with rsp_data = 0.
- RESP: rsp_valid held with stable rsp_data until rsp_ready; cmd_ready stays low until the response is consumed (one outstanding command).
- cmd_ready = 1 only in IDLE.

## Timing
- Reset values: tck 0, tms 1, tdi 0, cmd_ready 0, rsp_valid 0, rsp_data 0, busy 1; RST_SEQ begins on first clk after reset deasserts.
- Async reset mid-scan aborts immediately: outputs return to reset values, pending command discarded, no response issued, RST_SEQ restarts.
- TCK period = 2*CLK_DIV clk: low phase CLK_DIV cycles, then high phase CLK_DIV cycles. tck idles at 0.
- tms/tdi are registered and change only on the clk edge that drives tck 0→... low phase start (i.e. with the falling TCK edge); they are stable across the rising edge.
- tdo is sampled on the clk edge that drives tck 0→1 (no synchronizer; tdo is assumed settled since the preceding falling edge).
- Accept at edge N: first TCK low phase starts at N+1.
- rsp_valid rises on the clk after the last high phase ends; total latency for an accepted DR scan = (len+5)*2*CLK_DIV + 1 clk.
- rsp handshake completes at the edge with rsp_valid&rsp_ready; cmd_ready high the following cycle.

## Test plan
- Reset release, CLK_DIV=2: TMS sampled at rising tck = 1,1,1,1,1,0; cmd_ready rises after 24 clk + 1; tck 0 thereafter.
- DR scan len 8, data 0xA5, target with BYPASS selected (captures 0): TMS sequence 1,0,0,0×7,1,1,0 (13 periods); rsp_data = 0x4A.
- IR scan len 4, data 0x1, 4-bit IR capturing 0b0101: TMS 1,1,0,0,0,0,0,1,1,0; rsp_data = 0x5; target IR holds 0x1 after Update-IR.
- Backpressure: rsp_ready low 10 cycles after rsp_valid → rsp_valid/rsp_data stable, cmd_ready 0, tck 0, no new accept until handshake.
- Boundaries: cmd_len 0 → rsp_valid next cycle with 0, no tck edge; cmd_len 40 → exactly 32 shift periods (37 TCK periods total).
- Reset asserted mid-SHIFT of a len-16 scan → tck 0, tms 1, rsp_valid never asserts for that command, full 6-period reset sequence follows.

Source files
------------

// File: rtl/jtag_host.sv
// Host-side JTAG scan engine: divides clk into TCK, walks the target TAP through
// reset / DR / IR scans, shifts TDI LSB-first and gathers TDO into a response word.
module jtag_host #(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 32,
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LW-1:0]      cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo,
    output logic [2:0]         state_dbg
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW = (LW > 3) ? LW : 3;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

    // state_dbg encoding: 0 RST_SEQ, 1 IDLE, 2 PRE, 3 SHIFT, 4 POST, 5 RESP.
    typedef enum logic [2:0] {
        S_RST_SEQ = 3'd0,
        S_IDLE    = 3'd1,
        S_PRE     = 3'd2,
        S_SHIFT   = 3'd3,
        S_POST    = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DW-1:0]      div_q, div_d;
    logic               tck_q, tck_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               launch_q, launch_d;
    logic               is_ir_q, is_ir_d;
    logic               tap_cmd_q, tap_cmd_d;
    logic [LW-1:0]      len_q, len_d;
    logic [MAX_LEN-1:0] sr_q, sr_d;
    logic [MAX_LEN-1:0] cap_q, cap_d;

    logic               start_per;
    state_t             per_state;
    logic [CW-1:0]      per_cnt;

    // Last TCK period of each sequence state.
    function automatic logic per_last(input state_t s, input logic [CW-1:0] c,
                                      input logic ir, input logic [LW-1:0] len);
        case (s)
            S_RST_SEQ: per_last = (c == CW'(5));
            S_PRE:     per_last = (c == (ir ? CW'(3) : CW'(2)));
            S_SHIFT:   per_last = (c == CW'(len) - CW'(1));
            default:   per_last = (c == CW'(1));
        endcase
    endfunction

    // TMS driven for period c of sequence state s.
    function automatic logic per_tms(input state_t s, input logic [CW-1:0] c,
                                     input logic ir, input logic [LW-1:0] len);
        case (s)
            S_RST_SEQ: per_tms = (c != CW'(5));
            S_PRE:     per_tms = (c == CW'(0)) || (ir && (c == CW'(1)));
            S_SHIFT:   per_tms = (c == CW'(len) - CW'(1));
            default:   per_tms = (c == CW'(0));
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_RST_SEQ;
            cnt_q     <= '0;
            div_q     <= '0;
            tck_q     <= 1'b0;
            tms_q     <= 1'b1;
            tdi_q     <= 1'b0;
            launch_q  <= 1'b1;
            is_ir_q   <= 1'b0;
            tap_cmd_q <= 1'b0;
            len_q     <= '0;
            sr_q      <= '0;
            cap_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            tck_q     <= tck_d;
            tms_q     <= tms_d;
            tdi_q     <= tdi_d;
            launch_q  <= launch_d;
            is_ir_q   <= is_ir_d;
            tap_cmd_q <= tap_cmd_d;
            len_q     <= len_d;
            sr_q      <= sr_d;
            cap_q     <= cap_d;
        end
    end

    // Handshakes: a transfer happens on the clk edge where valid & ready are both 1;
    // valid is held with stable payload until then. One command in flight at a time.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        tck_d     = tck_q;
        tms_d     = tms_q;
        tdi_d     = tdi_q;
        launch_d  = launch_q;
        is_ir_d   = is_ir_q;
        tap_cmd_d = tap_cmd_q;
        len_d     = len_q;
        sr_d      = sr_q;
        cap_d     = cap_q;
        start_per = 1'b0;
        per_state = state_q;
        per_cnt   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cap_d   = '0;
                    sr_d    = cmd_data;
                    is_ir_d = (cmd_op == 2'd1);
                    len_d   = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
                    cnt_d   = '0;
                    if (cmd_op[1]) begin
                        state_d   = S_RST_SEQ;
                        launch_d  = 1'b1;
                        tap_cmd_d = 1'b1;
                    end else if (cmd_len == '0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d  = S_PRE;
                        launch_d = 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: begin
                if (launch_q) begin
                    launch_d  = 1'b0;
                    start_per = 1'b1;
                    per_cnt   = '0;
                end else if (div_q != DIV_LAST) begin
                    div_d = div_q + 1'b1;
                end else if (!tck_q) begin
                    // Rising TCK: target has held tdo since the falling edge.
                    tck_d = 1'b1;
                    div_d = '0;
                    if (state_q == S_SHIFT) cap_d = cap_q | (MAX_LEN'(tdo) << cnt_q);
                end else begin
                    tck_d = 1'b0;
                    div_d = '0;
                    if (!per_last(state_q, cnt_q, is_ir_q, len_q)) begin
                        start_per = 1'b1;
                        per_cnt   = cnt_q + 1'b1;
                    end else begin
                        case (state_q)
                            S_RST_SEQ: begin
                                state_d   = tap_cmd_q ? S_RESP : S_IDLE;
                                tap_cmd_d = 1'b0;
                            end
                            S_PRE: begin
                                start_per = 1'b1;
                                per_state = S_SHIFT;
                                per_cnt   = '0;
                            end
                            S_SHIFT: begin
                                start_per = 1'b1;
                                per_state = S_POST;
                                per_cnt   = '0;
                            end
                            default: state_d = S_RESP;
                        endcase
                    end
                end
            end
        endcase

        // A new period opens with TCK low; tms/tdi only change here.
        if (start_per) begin
            state_d = per_state;
            cnt_d   = per_cnt;
            div_d   = '0;
            tck_d   = 1'b0;
            tms_d   = per_tms(per_state, per_cnt, is_ir_q, len_q);
            if (per_state == S_SHIFT) begin
                tdi_d = sr_q[0];
                sr_d  = sr_q >> 1;
            end else begin
                tdi_d = 1'b0;
            end
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = cap_q;
    assign tck       = tck_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_jtag_host.sv
// Directed bench for jtag_host: behavioural TAP target (BYPASS DR, 4-bit IR
// capturing 0101) on the pins, hand-computed TMS streams, latencies and responses.
module tb_jtag_host;

    localparam int CLK_DIV = 2;
    localparam int MAX_LEN = 32;
    localparam int LW      = 6;
    localparam int LOG_N   = 512;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [LW-1:0]      cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [MAX_LEN-1:0] rsp_data;
    logic               busy;
    logic               tck;
    logic               tms;
    logic               tdi;
    logic               tdo;
    logic [2:0]         state_dbg;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1);
    end

    jtag_host #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
        .state_dbg(state_dbg)
    );

    // ---------------- target TAP model ----------------
    typedef enum logic [3:0] {
        TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
        SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR
    } tap_t;

    tap_t       tap_st = PADR;
    logic [3:0] ir_sr  = 4'h0;
    logic [3:0] ir_reg = 4'h0;
    logic       byp    = 1'b0;
    logic       tdo_t  = 1'b0;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR:   return m ? TLR   : RTI;
            RTI:   return m ? SELDR : RTI;
            SELDR: return m ? SELIR : CAPDR;
            CAPDR: return m ? EX1DR : SHDR;
            SHDR:  return m ? EX1DR : SHDR;
            EX1DR: return m ? UPDR  : PADR;
            PADR:  return m ? EX2DR : PADR;
            EX2DR: return m ? UPDR  : SHDR;
            UPDR:  return m ? SELDR : RTI;
            SELIR: return m ? TLR   : CAPIR;
            CAPIR: return m ? EX1IR : SHIR;
            SHIR:  return m ? EX1IR : SHIR;
            EX1IR: return m ? UPIR  : PAIR;
            PAIR:  return m ? EX2IR : PAIR;
            EX2IR: return m ? UPIR  : SHIR;
            default: return m ? SELDR : RTI;
        endcase
    endfunction

    always @(posedge tck) begin
        case (tap_st)
            CAPDR:   byp <= 1'b0;
            SHDR:    byp <= tdi;
            CAPIR:   ir_sr <= 4'b0101;
            SHIR:    ir_sr <= {tdi, ir_sr[3:1]};
            default: ;
        endcase
        tap_st <= tap_next(tap_st, tms);
    end

    always @(negedge tck) begin
        tdo_t <= (tap_st == SHDR) ? byp : (tap_st == SHIR) ? ir_sr[0] : 1'b0;
        if (tap_st == UPIR) ir_reg <= ir_sr;
        if (tap_st == TLR)  ir_reg <= 4'hE;
    end

    assign tdo = tdo_t;

    // TMS seen by the target at every rising TCK.
    int   tms_cnt = 0;
    logic tms_log [LOG_N];
    always @(posedge tck) begin
        if (tms_cnt < LOG_N) tms_log[tms_cnt] = tms;
        tms_cnt++;
    end

    function automatic logic [63:0] tms_seq(input int start, input int n);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < n && k < 64; k++)
            if (start + k < LOG_N) v[k] = tms_log[start + k];
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    int          mark  = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic accept_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
        int n;
        n = 0;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        mark = tms_cnt;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic scan(input string tag, input logic [1:0] op, input logic [5:0] len,
                        input logic [31:0] data, input logic [31:0] exp_rsp,
                        input int exp_lat, input int exp_ntck, input logic [63:0] exp_tms,
                        input int hold);
        int   lat;
        logic ok;
        exp_q.push_back(exp_rsp);
        accept_cmd(op, len, data);
        wait_rsp(lat);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_ntck"}, 64'(tms_cnt - mark), 64'(exp_ntck));
        check({tag, "_tms"}, tms_seq(mark, exp_ntck), exp_tms);
        check({tag, "_tap"}, 64'(tap_st), 64'(RTI));
        check({tag, "_rsp"}, 64'(rsp_data), 64'(exp_q.pop_front()));
        ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            ok &= (rsp_valid && rsp_data == exp_rsp && !cmd_ready && !tck && busy);
        end
        if (hold > 0) check({tag, "_hold"}, 64'(ok), 64'd1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, "_done"}, 64'({cmd_ready, rsp_valid, busy}), 64'h4);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int   n;
        logic rsp_seen;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_len   = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_pins", 64'({tck, tms, tdi}), 64'h2);
        check("reset_hs", 64'({cmd_ready, rsp_valid, busy}), 64'h1);
        check("reset_rsp_data", 64'(rsp_data), 64'h0);
        check("reset_state_dbg", 64'(state_dbg), 64'h0);

        // Power-on reset sequence: 6 TCK periods, ready after 24 + 1 clk.
        reset = 1'b0;
        mark  = tms_cnt;
        n     = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rstseq_ready_clk", 64'(n), 64'd25);
        check("rstseq_ntck", 64'(tms_cnt - mark), 64'd6);
        check("rstseq_tms", tms_seq(mark, 6), 64'h1F);
        check("rstseq_tap", 64'(tap_st), 64'(RTI));
        check("idle_state_dbg", 64'(state_dbg), 64'h1);
        repeat (8) @(negedge clk);
        check("idle_quiet", 64'({tck, busy}), 64'h0);
        check("idle_no_tck", 64'(tms_cnt - mark), 64'd6);

        // DR 8 bits through BYPASS, response held off for 10 cycles.
        scan("dr8", 2'd0, 6'd8, 32'h0000_00A5, 32'h0000_004A, 53, 13, 64'hC01, 10);

        // IR 4 bits: capture 0101, load 0001.
        scan("ir4", 2'd1, 6'd4, 32'h0000_0001, 32'h0000_0005, 41, 10, 64'h183, 0);
        check("ir4_ir_reg", 64'(ir_reg), 64'h1);

        // Zero-length scan: no TCK, immediate response.
        scan("len0", 2'd0, 6'd0, 32'hFFFF_FFFF, 32'h0, 0, 0, 64'h0, 0);

        // Over-long scan clamped to 32 shift periods.
        scan("len40", 2'd0, 6'd40, 32'hDEAD_BEEF, 32'hBD5B_7DDE, 149, 37, 64'hC_0000_0001, 0);

        // Short scan after a full-width one: upper response bits must be clear.
        scan("dr8b", 2'd0, 6'd8, 32'h0000_003C, 32'h0000_0078, 53, 13, 64'hC01, 0);

        // TAP reset commands (op 2 and reserved op 3).
        scan("tapres", 2'd2, 6'd8, 32'h0000_00FF, 32'h0, 25, 6, 64'h1F, 0);
        check("tapres_ir_reg", 64'(ir_reg), 64'hE);
        scan("op3", 2'd3, 6'd20, 32'h1234_5678, 32'h0, 25, 6, 64'h1F, 0);

        // Reset asserted during SHIFT of a 16-bit scan.
        accept_cmd(2'd0, 6'd16, 32'h0000_1234);
        n = 0;
        while (tms_cnt < mark + 6 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_in_shift", 64'({tck, tms}), 64'h2);
        reset = 1'b1;
        #1;
        check("abort_pins", 64'({tck, tms, tdi}), 64'h2);
        check("abort_hs", 64'({cmd_ready, rsp_valid, busy}), 64'h1);
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        mark     = tms_cnt;
        rsp_seen = 1'b0;
        n        = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            rsp_seen |= rsp_valid;
            n++;
        end
        check("abort_ready_clk", 64'(n), 64'd25);
        check("abort_no_rsp", 64'(rsp_seen), 64'h0);
        check("abort_ntck", 64'(tms_cnt - mark), 64'd6);
        check("abort_tms", tms_seq(mark, 6), 64'h1F);
        check("abort_tap", 64'(tap_st), 64'(RTI));

        // Engine still usable after the abort.
        scan("post_abort", 2'd0, 6'd8, 32'h0000_0081, 32'h0000_0002, 53, 13, 64'hC01, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
